// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver. Pins are synchronised and debounced in
// the clk domain, 11-bit frames are checked (start/parity/stop/timeout), E0/F0
// prefixes are folded into a single key event, and events are queued in a
// first-word-fall-through FIFO.
//
// Handshake: a head event is transferred on every rising clk edge where
// ev_valid and ev_ready are both high; while ev_valid is high and ev_ready is
// low the head fields hold steady; ev_ready with ev_valid low has no effect.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  output logic                              ev_valid,
  input  logic                              ev_ready,
  output logic [7:0]                        ev_code,
  output logic                              ev_ext,
  output logic                              ev_brk,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] clk_filt;
  logic [FILTER_LEN-1:0] data_filt;
  logic                  clk_db;
  logic                  data_db;
  logic                  clk_db_d;
  logic                  strobe;

  // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Debounce: the level only moves when the whole window agrees, else it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt  <= '1;
      data_filt <= '1;
      clk_db    <= 1'b1;
      data_db   <= 1'b1;
    end else begin
      clk_filt  <= {clk_filt[FILTER_LEN-2:0], clk_sync[1]};
      data_filt <= {data_filt[FILTER_LEN-2:0], data_sync[1]};
      if (&clk_filt)       clk_db <= 1'b1;
      else if (~|clk_filt) clk_db <= 1'b0;
      if (&data_filt)       data_db <= 1'b1;
      else if (~|data_filt) data_db <= 1'b0;
    end
  end

  // Registered one-cycle strobe on each falling edge of the debounced clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_db_d <= 1'b1;
      strobe   <= 1'b0;
    end else begin
      clk_db_d <= clk_db;
      strobe   <= clk_db_d & ~clk_db;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_err;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          byte_done_c;
  logic          par_fail_c;
  logic          frame_fail_c;

  assign timeout = (state_q != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

  // Inter-bit timer: restarts on every strobe and rests while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (strobe || state_q == S_IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a timeout abandons the frame, otherwise move on strobes.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (strobe) begin
      case (state_q)
        S_IDLE:   if (!data_db) state_d = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: frame verdict evaluated at the stop-bit strobe or on timeout.
  always_comb begin
    byte_done_c  = 1'b0;
    par_fail_c   = 1'b0;
    frame_fail_c = 1'b0;
    if (timeout) begin
      frame_fail_c = 1'b1;
    end else if (strobe && state_q == S_STOP) begin
      if (!data_db)           frame_fail_c = 1'b1;
      if (par_err)            par_fail_c   = 1'b1;
      if (data_db && !par_err) byte_done_c = 1'b1;
    end
  end

  // Frame datapath: bit counter, LSB-first shifter and parity verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_err <= 1'b0;
    end else if (strobe && !timeout) begin
      case (state_q)
        S_IDLE: begin
          bit_cnt <= 3'd0;
          par_err <= 1'b0;
        end
        S_DATA: begin
          shreg   <= {data_db, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_PARITY: par_err <= ~(^shreg ^ data_db);
        default: ;
      endcase
    end
  end

  // Registered frame results: decoded byte and error pulses.
  logic       byte_vld;
  logic [7:0] byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_vld   <= 1'b0;
      byte_q     <= 8'h00;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      byte_vld   <= byte_done_c;
      if (byte_done_c) byte_q <= shreg;
      err_parity <= par_fail_c;
      err_frame  <= frame_fail_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  logic       ext_flag;
  logic       brk_flag;
  logic       is_e0;
  logic       is_f0;
  logic       push;
  logic [9:0] push_word;

  assign is_e0     = (byte_q == 8'hE0);
  assign is_f0     = (byte_q == 8'hF0);
  assign push      = byte_vld && !is_e0 && !is_f0;
  assign push_word = {byte_q, ext_flag, brk_flag};

  // Prefix flags: set by E0/F0, consumed by the next key byte, cleared on errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (err_parity || err_frame) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_vld) begin
      if (is_e0) begin
        ext_flag <= 1'b1;
      end else if (is_f0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [9:0]    head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);

  // Storage array; contents are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // Pointers, occupancy and the overflow pulse for dropped events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= push && full && !pop;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_valid   = (count != '0);
  assign ev_code    = ev_valid ? head[9:2] : 8'h00;
  assign ev_ext     = ev_valid ? head[1]   : 1'b0;
  assign ev_brk     = ev_valid ? head[0]   : 1'b0;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins and
// every expectation is hand-derived from the frame contents and pipeline depth.
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN  = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 500;
  localparam int CW          = $clog2(FIFO_DEPTH + 1);
  localparam int HALF        = 20;   // clk cycles per PS/2 clock phase

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          ps2_clk;
  logic          ps2_data;
  logic          ev_valid;
  logic          ev_ready;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_brk;
  logic [CW-1:0] fifo_count;
  logic          err_parity;
  logic          err_frame;
  logic          overflow;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_brk    (ev_brk),
    .fifo_count(fifo_count),
    .err_parity(err_parity),
    .err_frame (err_frame),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;
  int lat;
  logic [7:0] exp_q[$];

  // Pulse counters (each high cycle counts once).
  always @(negedge clk) begin
    if (!rst) begin
      if (err_parity) n_perr++;
      if (err_frame)  n_ferr++;
      if (overflow)   n_ovf++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par,
                                        input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Sends bits 0..nbits-1 of fr. During the stop-bit low phase it records the
  // first cycle ev_valid is seen high (lat) and, if pop_at > 0, pulses
  // ev_ready so that it is sampled at clock edge pop_at+1 after the fall.
  task automatic send_frame(input logic [10:0] fr, input int nbits, input int pop_at);
    lat = 0;
    for (int b = 0; b < nbits; b++) begin
      ps2_data = fr[b];
      idle(HALF / 2);
      ps2_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        tick();
        if (b == 10) begin
          if (lat == 0 && ev_valid) lat = i;
          if (pop_at > 0) ev_ready = (i == pop_at);
        end
      end
      ps2_clk = 1'b1;
      idle(HALF / 2);
    end
    ps2_data = 1'b1;
    idle(HALF / 2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(frame(b, 1'b0, 1'b0), 11, 0);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b0;
    idle(3);
    checks++;
    if ({ev_valid, ev_ext, ev_brk, err_parity, err_frame, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {ev_valid, ev_ext, ev_brk, err_parity, err_frame, overflow});
    end
    rst = 1'b0;
    idle(4);
    checks++;
    if (ev_code !== 8'h00 || fifo_count !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: got code=%h count=%0d valid=%b expected code=00 count=0 valid=0",
               ev_code, fifo_count, ev_valid);
    end
  endtask

  task automatic test_basic();
    send_frame(frame(8'h1C, 1'b0, 1'b0), 11, 0);
    checks++;
    if (lat !== FILTER_LEN + 6) begin
      errors++;
      $display("FAIL basic_latency: ev_valid rose %0d cycles after stop fall, expected %0d",
               lat, FILTER_LEN + 6);
    end
    checks++;
    if (ev_valid !== 1'b1 || ev_code !== 8'h1C || ev_ext !== 1'b0 || ev_brk !== 1'b0) begin
      errors++;
      $display("FAIL basic_event: got valid=%b code=%h ext=%b brk=%b expected 1 1c 0 0",
               ev_valid, ev_code, ev_ext, ev_brk);
    end
    checks++;
    if (fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 1", fifo_count);
    end
    // Head must hold while not accepted.
    idle(5);
    checks++;
    if (ev_code !== 8'h1C || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL basic_hold: got code=%h count=%0d expected 1c 1", ev_code, fifo_count);
    end
    pop_one();
    checks++;
    if (fifo_count !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: got count=%0d valid=%b expected 0 0", fifo_count, ev_valid);
    end
    // ev_ready while empty is ignored.
    pop_one();
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL empty_pop: got count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_prefix();
    send_byte(8'hE0);
    send_byte(8'hF0);
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL prefix_nopush: got count=%0d expected 0", fifo_count);
    end
    send_byte(8'h75);
    checks++;
    if (fifo_count !== CW'(1) || ev_code !== 8'h75 || ev_ext !== 1'b1 || ev_brk !== 1'b1) begin
      errors++;
      $display("FAIL prefix_e0f075: got count=%0d code=%h ext=%b brk=%b expected 1 75 1 1",
               fifo_count, ev_code, ev_ext, ev_brk);
    end
    pop_one();
    send_byte(8'h29);
    checks++;
    if (fifo_count !== CW'(1) || ev_code !== 8'h29 || ev_ext !== 1'b0 || ev_brk !== 1'b0) begin
      errors++;
      $display("FAIL prefix_cleared: got count=%0d code=%h ext=%b brk=%b expected 1 29 0 0",
               fifo_count, ev_code, ev_ext, ev_brk);
    end
    pop_one();
  endtask

  task automatic test_errors();
    int p0;
    int f0;
    p0 = n_perr; f0 = n_ferr;
    send_frame(frame(8'h1C, 1'b1, 1'b0), 11, 0);
    checks++;
    if (n_perr - p0 !== 1 || n_ferr - f0 !== 0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL err_parity: got perr=%0d ferr=%0d count=%0d expected 1 0 0",
               n_perr - p0, n_ferr - f0, fifo_count);
    end
    p0 = n_perr; f0 = n_ferr;
    send_frame(frame(8'h1C, 1'b0, 1'b1), 11, 0);
    checks++;
    if (n_perr - p0 !== 0 || n_ferr - f0 !== 1 || fifo_count !== '0) begin
      errors++;
      $display("FAIL err_stop: got perr=%0d ferr=%0d count=%0d expected 0 1 0",
               n_perr - p0, n_ferr - f0, fifo_count);
    end
    send_byte(8'hE0);
    send_frame(frame(8'h12, 1'b1, 1'b0), 11, 0);
    send_byte(8'h74);
    checks++;
    if (fifo_count !== CW'(1) || ev_code !== 8'h74 || ev_ext !== 1'b0 || ev_brk !== 1'b0) begin
      errors++;
      $display("FAIL err_clears_ext: got count=%0d code=%h ext=%b brk=%b expected 1 74 0 0",
               fifo_count, ev_code, ev_ext, ev_brk);
    end
    pop_one();
  endtask

  task automatic test_timeout();
    int f0;
    int p0;
    int seen;
    int from_strobe;
    f0 = n_ferr; p0 = n_perr; seen = 0;
    send_frame(frame(8'h1C, 1'b0, 1'b0), 5, 0);
    for (int w = 1; w <= TIMEOUT_CYC + 100; w++) begin
      tick();
      if (err_frame) begin
        seen = w;
        break;
      end
    end
    // Last strobe came FILTER_LEN+4 cycles after the last pin fall; send_frame
    // returned 2*HALF cycles after that fall.
    from_strobe = seen + 2 * HALF - (FILTER_LEN + 4);
    checks++;
    if (seen == 0 || from_strobe < TIMEOUT_CYC || from_strobe > TIMEOUT_CYC + 2) begin
      errors++;
      $display("FAIL timeout_pulse: err_frame %0d cycles after last strobe (seen=%0d), expected %0d..%0d",
               from_strobe, seen, TIMEOUT_CYC, TIMEOUT_CYC + 2);
    end
    idle(5);
    checks++;
    if (n_ferr - f0 !== 1 || n_perr - p0 !== 0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL timeout_counts: got ferr=%0d perr=%0d count=%0d expected 1 0 0",
               n_ferr - f0, n_perr - p0, fifo_count);
    end
    send_byte(8'h1C);
    checks++;
    if (fifo_count !== CW'(1) || ev_code !== 8'h1C) begin
      errors++;
      $display("FAIL timeout_recover: got count=%0d code=%h expected 1 1c", fifo_count, ev_code);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] exp_code;
    ev_ready = 1'b0;
    o0 = n_ovf;
    for (int k = 1; k <= 9; k++) begin
      send_byte(8'(k));
      if (k <= FIFO_DEPTH) exp_q.push_back(8'(k));
    end
    checks++;
    if (fifo_count !== CW'(FIFO_DEPTH) || n_ovf - o0 !== 1) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d overflow_pulses=%0d expected 8 1",
               fifo_count, n_ovf - o0);
    end
    while (exp_q.size() > 0) begin
      exp_code = exp_q.pop_front();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== exp_code) begin
        errors++;
        $display("FAIL ovf_order: got valid=%b code=%h expected 1 %h", ev_valid, ev_code, exp_code);
      end
      pop_one();
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL ovf_drain: got count=%0d expected 0", fifo_count);
    end

    // Pop in the same cycle as the ninth push: accepted, no overflow.
    o0 = n_ovf;
    for (int k = 1; k <= FIFO_DEPTH; k++) send_byte(8'(8'h10 + k));
    send_frame(frame(8'h19, 1'b0, 1'b0), 11, FILTER_LEN + 5);
    ev_ready = 1'b0;
    for (int k = 2; k <= 9; k++) exp_q.push_back(8'(8'h10 + k));
    checks++;
    if (fifo_count !== CW'(FIFO_DEPTH) || n_ovf - o0 !== 0) begin
      errors++;
      $display("FAIL popfull_count: got count=%0d overflow_pulses=%0d expected 8 0",
               fifo_count, n_ovf - o0);
    end
    while (exp_q.size() > 0) begin
      exp_code = exp_q.pop_front();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== exp_code) begin
        errors++;
        $display("FAIL popfull_order: got valid=%b code=%h expected 1 %h", ev_valid, ev_code, exp_code);
      end
      pop_one();
    end
  endtask

  task automatic test_glitch();
    int f0;
    int p0;
    f0 = n_ferr; p0 = n_perr;
    // Data held low (looks like a start bit) while the clock glitches briefly.
    ps2_data = 1'b0;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    idle(HALF);
    ps2_data = 1'b1;
    idle(HALF);
    send_byte(8'h1C);
    checks++;
    if (fifo_count !== CW'(1) || ev_code !== 8'h1C || n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin
      errors++;
      $display("FAIL glitch: got count=%0d code=%h ferr=%0d perr=%0d expected 1 1c 0 0",
               fifo_count, ev_code, n_ferr - f0, n_perr - p0);
    end
    pop_one();
  endtask

  task automatic test_reset_mid();
    int f0;
    int p0;
    send_byte(8'hE0);
    send_frame(frame(8'h1C, 1'b0, 1'b0), 6, 0);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    f0 = n_ferr; p0 = n_perr;
    idle(TIMEOUT_CYC + 50);
    checks++;
    if (n_ferr - f0 !== 0 || n_perr - p0 !== 0 || fifo_count !== '0 || ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got ferr=%0d perr=%0d count=%0d valid=%b expected 0 0 0 0",
               n_ferr - f0, n_perr - p0, fifo_count, ev_valid);
    end
    send_byte(8'h1C);
    checks++;
    if (fifo_count !== CW'(1) || ev_code !== 8'h1C || ev_ext !== 1'b0 || ev_brk !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: got count=%0d code=%h ext=%b brk=%b expected 1 1c 0 0",
               fifo_count, ev_code, ev_ext, ev_brk);
    end
    pop_one();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_errors();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver. The whole block runs in the `clk` domain: no logic is clocked by the PS/2 clock. It synchronises and debounces the PS/2 lines, checks each 11-bit frame (start, parity, stop, inter-bit timeout), and folds the E0/F0 prefixes into single key events. Events are buffered in a FIFO with a valid/ready handshake for the game input logic.

## Interface
- `FILTER_LEN`, 8: debounce window in `clk` cycles (≥2).
- `FIFO_DEPTH`, 8: event FIFO entries (power of 2, ≥2).
- `TIMEOUT_CYC`, 200000: maximum `clk` cycles between bit strobes inside a frame.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out 8: scan code of the head event.
- `ev_ext` out 1: head event was preceded by E0.
- `ev_brk` out 1: head event was preceded by F0 (key release).
- `fifo_count` out $clog2(FIFO_DEPTH+1): number of entries held.
- `err_parity` out 1: one-cycle pulse on a parity error.
- `err_frame` out 1: one-cycle pulse on a bad stop bit or a timeout.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Input conditioning:** each pin passes through a 2-flop synchroniser, then a `FILTER_LEN` shift register. The debounced level goes to 1 only when the window is all ones and to 0 only when it is all zeros; otherwise it holds. A falling edge of the debounced clock produces a registered one-cycle `strobe`.
- **Frame FSM:** states IDLE, DATA, PARITY, STOP. All transitions happen on `strobe` only.
  - IDLE: debounced data 0 → DATA with bit count 0. Debounced data 1 → stay in IDLE (spurious edge ignored, no error).
  - DATA: shift debounced data in LSB-first. After the 8th bit → PARITY.
  - PARITY: odd parity. XOR of the 8 data bits and the parity bit must be 1; otherwise record a parity error. Either way → STOP.
  - STOP: data 1 and no parity error → byte done. Data 0 → `err_frame` pulse. A recorded parity error → `err_parity` pulse. Every case → IDLE.
- **Timeout:** a counter clears on every `strobe`. If the FSM is not in IDLE and the counter reaches `TIMEOUT_CYC`, the FSM returns to IDLE, pulses `err_frame`, and discards the partial byte.
- **Prefix decoder:**
  - Byte E0 sets the `ext` flag; byte F0 sets the `brk` flag. Neither is pushed.
  - Any other byte pushes {code, `ext`, `brk`} and clears both flags.
  - Any parity, frame or timeout error clears both flags.
- **FIFO:** first-word-fall-through.
  - `ev_valid` = (`fifo_count` ≠ 0). Head fields are stable while `ev_valid` is high and `ev_ready` is low.
  - Pop when `ev_valid` && `ev_ready`. `ev_ready` while empty is ignored.
  - Push while full with no pop: the new event is dropped and `overflow` pulses. Push while full with a pop in the same cycle: accepted, `fifo_count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- **Reset values:** debounced lines 1; filters all 1; FSM IDLE; flags 0; FIFO empty. All outputs 0, including `ev_code` 0 and `fifo_count` 0.
- A stable pin transition changes the debounced level `FILTER_LEN`+3 cycles later. `strobe` follows one cycle after that.
- Pin glitches shorter than `FILTER_LEN` cycles never change the debounced level.
- `ev_valid` rises exactly 2 cycles after the stop-bit `strobe`: byte decode +1, FIFO write +2.
- Error pulses assert 1 cycle after the stop-bit `strobe`, or 1 cycle after the timeout count is reached.
- `rst` mid-frame or mid-prefix: all state returns to reset values immediately; no event or error is emitted.
- Throughput: at most one event per frame. Pop is available every cycle.

## Test plan
- **Basic frame:** `ev_ready`=0; send frame 0x1C (data 00111000 LSB-first, parity 0, stop 1) → `ev_valid`=1, `ev_code`=0x1C, `ev_ext`=0, `ev_brk`=0, `fifo_count`=1. Raise `ev_ready` for one cycle → count 0.
- **Prefix folding:** send E0, F0, 75 → exactly one event: `ev_code`=0x75, `ev_ext`=1, `ev_brk`=1. Then send 29 → event 0x29 with `ev_ext`=0, `ev_brk`=0.
- **Error handling:** send 0x1C with parity 1 → one `err_parity` pulse, no event. Send 0x1C with stop 0 → one `err_frame` pulse, no event. Send E0 then a bad frame then 0x74 → event 0x74 with `ev_ext`=0.
- **Timeout recovery:** send start bit plus 4 data bits, then idle → `err_frame` pulse `TIMEOUT_CYC` cycles after the last strobe. Next valid 0x1C is received correctly.
- **Overflow and pop-while-full:** `ev_ready`=0; send 9 codes 0x01..0x09 → `fifo_count`=8, one `overflow` pulse, and pops return 0x01..0x08 in order. Repeat with `ev_ready`=1 on the 9th push cycle → no overflow.
- **Glitch and reset:** a `ps2_clk` low pulse of `FILTER_LEN`-1 cycles → no strobe, FSM stays in IDLE. `rst` after 5 data bits → no pulses, and the following frame decodes correctly.
